// File: rtl/salida_serial_pkg.sv
// Shared definitions for the electrode-pattern serial output path:
// FSM state encoding, default sizes and the reference pattern words.
package salida_serial_pkg;

  localparam int WIDTH_DEF   = 11;
  localparam int CLK_DIV_DEF = 4;

  // Reference electrode patterns, also stored in the pattern ROM.
  localparam logic [WIDTH_DEF-1:0] PATRON_REPOSO = 11'b11111111111;
  localparam logic [WIDTH_DEF-1:0] PATRON_ALARMA = 11'b10110000110;

  typedef enum logic [2:0] {
    REPOSO = 3'd0,
    BAJO   = 3'd1,
    ALTO   = 3'd2,
    LATCH  = 3'd3,
    FIN    = 3'd4
  } estado_t;

  // ceil(log2(n)), never narrower than one bit so counters stay legal.
  function automatic int ancho_min1(input int n);
    int w;
    w = $clog2(n);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/salida_serial_div_fase.sv
// Phase divider: counts CLK_DIV enabled cycles and raises a one-cycle
// tick on the last one, wrapping to zero so each phase starts clean.
module div_fase
  import salida_serial_pkg::*;
#(
  parameter int CLK_DIV = CLK_DIV_DEF
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr_i,
  input  logic en_i,
  output logic tick_o
);

  localparam int             FW     = ancho_min1(CLK_DIV + 1);
  localparam logic [FW-1:0]  ULTIMO = FW'(CLK_DIV - 1);

  logic [FW-1:0] cnt_q;
  logic [FW-1:0] cnt_d;

  // Next count: clear has priority, tick on the final cycle of a phase.
  always_comb begin
    cnt_d  = cnt_q;
    tick_o = 1'b0;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i) begin
      if (cnt_q == ULTIMO) begin
        cnt_d  = '0;
        tick_o = 1'b1;
      end else begin
        cnt_d = cnt_q + FW'(1);
      end
    end
  end

  // Phase count register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/salida_serial.sv
// Serialiser for the electrode pattern word: shifts patron MSB first to an
// external shift register (sdata/sclk), then strobes its output latch.
// Every output comes straight from a flop loaded with next-state values,
// so outputs line up with the state register and never see inputs directly.
module salida_serial
  import salida_serial_pkg::*;
#(
  parameter int WIDTH   = WIDTH_DEF,
  parameter int CLK_DIV = CLK_DIV_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] patron,
  input  logic             cargar,
  output logic             sdata,
  output logic             sclk,
  output logic             slatch,
  output logic             ocupado,
  output logic             listo
);

  localparam int            BW       = ancho_min1(WIDTH);
  localparam logic [BW-1:0] BIT_ALTO = BW'(WIDTH - 1);

  estado_t          state_q, state_d;
  logic [WIDTH-1:0] sr_q, sr_d;
  logic [WIDTH-1:0] enviado_q, enviado_d;
  logic [BW-1:0]    bit_q, bit_d;
  logic             pendiente_q, pendiente_d;

  logic sdata_q, sdata_d;
  logic sclk_q, sclk_d;
  logic slatch_q, slatch_d;
  logic ocupado_q, ocupado_d;
  logic listo_q, listo_d;

  logic fase_clr;
  logic fase_en;
  logic fase_tick;

  div_fase #(
    .CLK_DIV(CLK_DIV)
  ) u_div_fase (
    .clk   (clk),
    .rst_n (rst_n),
    .clr_i (fase_clr),
    .en_i  (fase_en),
    .tick_o(fase_tick)
  );

  // Next-state logic: start detection in REPOSO, phase-timed bit shifting.
  always_comb begin
    state_d     = state_q;
    sr_d        = sr_q;
    enviado_d   = enviado_q;
    bit_d       = bit_q;
    pendiente_d = pendiente_q;
    fase_clr    = 1'b0;
    fase_en     = 1'b0;
    unique case (state_q)
      REPOSO: begin
        fase_clr = 1'b1;
        // A changed pattern restarts on its own; cargar forces a resend.
        if (cargar || (patron != enviado_q) || pendiente_q) begin
          sr_d        = patron;
          enviado_d   = patron;
          bit_d       = BIT_ALTO;
          pendiente_d = 1'b0;
          state_d     = BAJO;
        end
      end
      BAJO: begin
        fase_en = 1'b1;
        if (fase_tick) begin
          state_d = ALTO;
        end
      end
      ALTO: begin
        fase_en = 1'b1;
        if (fase_tick) begin
          sr_d = sr_q << 1;
          if (bit_q == '0) begin
            state_d = LATCH;
          end else begin
            bit_d   = bit_q - BW'(1);
            state_d = BAJO;
          end
        end
      end
      LATCH: begin
        fase_en = 1'b1;
        if (fase_tick) begin
          state_d = FIN;
        end
      end
      FIN: begin
        fase_clr = 1'b1;
        state_d  = REPOSO;
      end
      default: begin
        fase_clr = 1'b1;
        state_d  = REPOSO;
      end
    endcase
  end

  // Output values for the coming state; data line is held low outside bits.
  always_comb begin
    sdata_d   = ((state_d == BAJO) || (state_d == ALTO)) ? sr_d[WIDTH-1] : 1'b0;
    sclk_d    = (state_d == ALTO);
    slatch_d  = (state_d == LATCH);
    ocupado_d = (state_d != REPOSO);
    listo_d   = (state_d == FIN);
  end

  // State, datapath and output registers; reset leaves a transfer pending.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= REPOSO;
      sr_q        <= '0;
      enviado_q   <= '0;
      bit_q       <= '0;
      pendiente_q <= 1'b1;
      sdata_q     <= 1'b0;
      sclk_q      <= 1'b0;
      slatch_q    <= 1'b0;
      ocupado_q   <= 1'b0;
      listo_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      sr_q        <= sr_d;
      enviado_q   <= enviado_d;
      bit_q       <= bit_d;
      pendiente_q <= pendiente_d;
      sdata_q     <= sdata_d;
      sclk_q      <= sclk_d;
      slatch_q    <= slatch_d;
      ocupado_q   <= ocupado_d;
      listo_q     <= listo_d;
    end
  end

  assign sdata   = sdata_q;
  assign sclk    = sclk_q;
  assign slatch  = slatch_q;
  assign ocupado = ocupado_q;
  assign listo   = listo_q;

endmodule

// File: tb/tb_salida_serial.sv
// Bench for salida_serial: a CLK_DIV=2 instance driven by a frame table and
// hand-written corner sequences, plus a CLK_DIV=1 instance for fast timing.
module tb_salida_serial;
  import salida_serial_pkg::*;

  localparam int W = 11;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst_n, cargar;
  logic [W-1:0] patron;
  logic         sdata, sclk, slatch, ocupado, listo;

  logic         rst1_n, cargar1;
  logic [W-1:0] patron1;
  logic         sdata1, sclk1, slatch1, ocupado1, listo1;

  salida_serial #(.WIDTH(W), .CLK_DIV(2)) dut (
    .clk(clk), .rst_n(rst_n), .patron(patron), .cargar(cargar),
    .sdata(sdata), .sclk(sclk), .slatch(slatch), .ocupado(ocupado), .listo(listo)
  );

  salida_serial #(.WIDTH(W), .CLK_DIV(1)) dut1 (
    .clk(clk), .rst_n(rst1_n), .patron(patron1), .cargar(cargar1),
    .sdata(sdata1), .sclk(sclk1), .slatch(slatch1), .ocupado(ocupado1), .listo(listo1)
  );

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic         started;
    logic [W-1:0] word;
    int           nbits;
    int           busy;
    int           latch_len;
    int           listo_n;
    int           listo_at;
    int           unstable;
    int           gap;
  } frame_t;

  typedef struct {
    logic [W-1:0] patron;
    logic         cargar;
    logic         exp_start;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end else begin
      $display("ok   %s = %0d", name, act);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, ".sdata"},   32'(sdata),   0);
    chk({tag, ".sclk"},    32'(sclk),    0);
    chk({tag, ".slatch"},  32'(slatch),  0);
    chk({tag, ".ocupado"}, 32'(ocupado), 0);
    chk({tag, ".listo"},   32'(listo),   0);
  endtask

  // Waits (bounded) for a frame on dut and records it cycle by cycle.
  // kind 1: cargar pulse at busy cycles ev1/ev2; 2: patron <= ev_pat;
  // 3: assert reset at ev1 and stop observing.
  task automatic run_frame(input int ev1, input int ev2, input int kind,
                           input logic [W-1:0] ev_pat, output frame_t f);
    logic prev_sclk, prev_sdata, held;
    f = '{default: 0};
    while (!ocupado && f.gap < 20) begin
      step();
      f.gap++;
    end
    if (!ocupado) return;
    f.started  = 1'b1;
    prev_sclk  = 1'b0;
    prev_sdata = sdata;
    held       = 1'b0;
    while (ocupado && f.busy < 200) begin
      f.busy++;
      if (sclk && !prev_sclk) begin
        f.word = {f.word[W-2:0], sdata};
        f.nbits++;
        held = sdata;
        if (sdata !== prev_sdata) f.unstable++;
      end else if (sclk && (sdata !== held)) begin
        f.unstable++;
      end
      if (slatch) begin
        f.latch_len++;
        if (sdata !== 1'b0 || sclk !== 1'b0) f.unstable++;
      end
      if (listo) begin
        f.listo_n++;
        f.listo_at = f.busy;
      end
      if (f.busy == ev1 || f.busy == ev2) begin
        if (kind == 1) cargar = 1'b1;
        if (kind == 2) patron = ev_pat;
        if (kind == 3) begin
          rst_n = 1'b0;
          #1;
          chk_zero("reset_mid");
          break;
        end
      end
      prev_sclk  = sclk;
      prev_sdata = sdata;
      step();
      cargar = 1'b0;
    end
  endtask

  task automatic check_frame(input string tag, input frame_t f, input logic [W-1:0] exp_word);
    chk({tag, ".started"},  32'(f.started), 1);
    chk({tag, ".word"},     32'(f.word), 32'(exp_word));
    chk({tag, ".nbits"},    32'(f.nbits), 11);
    chk({tag, ".busy"},     32'(f.busy), 47);
    chk({tag, ".latch"},    32'(f.latch_len), 2);
    chk({tag, ".listo_n"},  32'(f.listo_n), 1);
    chk({tag, ".listo_at"}, 32'(f.listo_at), 47);
    chk({tag, ".unstable"}, 32'(f.unstable), 0);
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    frame_t f;
    vec_t   tbl[7];
    string  tag;

    tbl[0] = '{PATRON_ALARMA,  1'b0, 1'b1};
    tbl[1] = '{PATRON_ALARMA,  1'b0, 1'b0};
    tbl[2] = '{PATRON_ALARMA,  1'b1, 1'b1};
    tbl[3] = '{11'b01010101010, 1'b0, 1'b1};
    tbl[4] = '{11'b00000000001, 1'b1, 1'b1};
    tbl[5] = '{11'b00000000001, 1'b0, 1'b0};
    tbl[6] = '{11'b10000000000, 1'b0, 1'b1};

    rst_n   = 1'b0;
    cargar  = 1'b0;
    patron  = PATRON_REPOSO;
    rst1_n  = 1'b0;
    cargar1 = 1'b0;
    patron1 = PATRON_ALARMA;

    // Reset state and the frame that must follow reset release.
    step(); step(); step();
    chk_zero("reset");
    rst_n = 1'b1;
    run_frame(0, 0, 0, '0, f);
    chk("post_reset.gap", 32'(f.gap), 1);
    check_frame("post_reset", f, PATRON_REPOSO);

    // Table of pattern/cargar combinations.
    for (int i = 0; i < 7; i++) begin
      tag    = $sformatf("vec%0d", i);
      patron = tbl[i].patron;
      cargar = tbl[i].cargar;
      run_frame(0, 0, 0, '0, f);
      cargar = 1'b0;
      if (tbl[i].exp_start) begin
        check_frame(tag, f, tbl[i].patron);
      end else begin
        chk({tag, ".started"}, 32'(f.started), 0);
      end
    end

    // cargar while busy is ignored, and no restart on an unchanged word.
    cargar = 1'b1;
    run_frame(5, 30, 1, '0, f);
    check_frame("cargar_busy", f, 11'b10000000000);
    run_frame(0, 0, 0, '0, f);
    chk("cargar_busy.restart", 32'(f.started), 0);

    // Pattern change mid-frame: bits in flight untouched, new frame follows.
    patron = PATRON_REPOSO;
    run_frame(10, 0, 2, PATRON_ALARMA, f);
    check_frame("cambio.first", f, PATRON_REPOSO);
    run_frame(0, 0, 0, '0, f);
    chk("cambio.gap", 32'(f.gap), 1);
    check_frame("cambio.second", f, PATRON_ALARMA);
    run_frame(0, 0, 0, '0, f);
    chk("cambio.idle", 32'(f.started), 0);

    // Reset at busy cycle 20 aborts without a latch strobe, then resends.
    cargar = 1'b1;
    run_frame(20, 0, 3, '0, f);
    chk("abort.busy", 32'(f.busy), 20);
    chk("abort.latch", 32'(f.latch_len), 0);
    chk("abort.listo", 32'(f.listo_n), 0);
    step();
    chk_zero("abort_hold");
    rst_n = 1'b1;
    run_frame(0, 0, 0, '0, f);
    chk("resend.gap", 32'(f.gap), 1);
    check_frame("resend", f, PATRON_ALARMA);

    // CLK_DIV=1 instance: 24-cycle busy, 2-cycle sclk period.
    begin
      logic [W-1:0] word1;
      int busy1, nbits1, latch1, listo_at1, bad_period, unstable1, last_rise, gap1;
      logic prev_sclk1, prev_sdata1;
      word1 = '0; busy1 = 0; nbits1 = 0; latch1 = 0; listo_at1 = 0;
      bad_period = 0; unstable1 = 0; last_rise = 0; gap1 = 0;
      rst1_n = 1'b1;
      while (!ocupado1 && gap1 < 20) begin
        step();
        gap1++;
      end
      prev_sclk1  = 1'b0;
      prev_sdata1 = sdata1;
      while (ocupado1 && busy1 < 100) begin
        busy1++;
        if (sclk1 && !prev_sclk1) begin
          word1 = {word1[W-2:0], sdata1};
          nbits1++;
          if (sdata1 !== prev_sdata1) unstable1++;
          if (last_rise != 0 && (busy1 - last_rise) != 2) bad_period++;
          last_rise = busy1;
        end
        if (slatch1) latch1++;
        if (listo1) listo_at1 = busy1;
        prev_sclk1  = sclk1;
        prev_sdata1 = sdata1;
        step();
      end
      chk("div1.gap",      32'(gap1), 1);
      chk("div1.busy",     32'(busy1), 24);
      chk("div1.word",     32'(word1), 32'(PATRON_ALARMA));
      chk("div1.nbits",    32'(nbits1), 11);
      chk("div1.period",   32'(bad_period), 0);
      chk("div1.unstable", 32'(unstable1), 0);
      chk("div1.latch",    32'(latch1), 1);
      chk("div1.listo_at", 32'(listo_at1), 24);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/salida_serial.md
SALIDA_SERIAL -- requirements
Module: salida_serial

Interface
REQ-001 Parameter WIDTH, default 11, number of pattern bits per transfer (matches the electrode pattern ROM word).
REQ-002 Parameter CLK_DIV, default 4, clk cycles per sclk half-period; legal range 1..255.
REQ-003 clk  input  1  single system clock; all state updates on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-005 patron  input  WIDTH  electrode pattern word from the pattern ROM, bit WIDTH-1 sent first.
REQ-006 cargar  input  1  transfer request, sampled every cycle, level or pulse.
REQ-007 sdata  output  1  serial data to external shift register.
REQ-008 sclk  output  1  serial shift clock; external device samples on rising edge.
REQ-009 slatch  output  1  output-latch strobe, active-high.
REQ-010 ocupado  output  1  high while a transfer is in progress.
REQ-011 listo  output  1  one-cycle pulse marking transfer completion.

Function
REQ-012 The FSM SHALL have states REPOSO, BAJO, ALTO, LATCH, FIN.
REQ-013 In REPOSO a transfer SHALL start when cargar=1, patron differs from register enviado, or flag pendiente=1.
REQ-014 On start, patron SHALL be captured into shift register sr and into enviado, bit counter set to WIDTH-1, pendiente cleared, next state BAJO.
REQ-015 BAJO: sclk=0, sdata=sr[WIDTH-1], held CLK_DIV cycles, then ALTO.
REQ-016 ALTO: sclk=1, sdata unchanged, held CLK_DIV cycles; at exit sr shifts left one (zero fill); if counter=0 go LATCH else decrement and go BAJO.
REQ-017 LATCH: sclk=0, sdata=0, slatch=1 for CLK_DIV cycles, then FIN.
REQ-018 FIN: listo=1 for exactly one cycle, then REPOSO.
REQ-019 ocupado SHALL be 1 in BAJO, ALTO, LATCH, FIN; 0 in REPOSO; busy length = (2*WIDTH+1)*CLK_DIV+1 cycles (47 at WIDTH=11, CLK_DIV=2).
REQ-020 First BAJO cycle SHALL be the cycle after the start condition is sampled.
REQ-021 cargar while ocupado=1 SHALL be ignored (not queued).
REQ-022 A patron change during a transfer SHALL not alter bits in flight; the REPOSO compare then starts a new transfer with the new value.
REQ-023 All outputs SHALL be registered; no combinational path from inputs to outputs.
REQ-024 Phase counter SHALL be ceil(log2(CLK_DIV+1)) bits and wrap to 0 at each phase change; bit counter ceil(log2(WIDTH)) bits.

Reset
REQ-025 rst_n=0 SHALL immediately force state REPOSO, sdata=0, sclk=0, slatch=0, ocupado=0, listo=0, sr=0, enviado=0, counters=0.
REQ-026 Reset SHALL set pendiente=1 so one transfer of the current patron always follows reset release.
REQ-027 Reset mid-transfer SHALL abort with no slatch pulse; the post-reset transfer resends the full word.

Structure
REQ-028 A shared package SHALL hold the state encoding, WIDTH default, and the pattern constants PATRON_REPOSO=11'b11111111111 and PATRON_ALARMA=11'b10110000110 used by the ROM and bench.
REQ-029 The phase divider SHALL be a sub-module div_fase (count to CLK_DIV, one-cycle tick output, sync clear).

Verification
REQ-030 Reset release with patron=11'b11111111111, CLK_DIV=2 -> 11 sclk rising edges each with sdata=1, one 2-cycle slatch pulse, listo at busy cycle 47.
REQ-031 patron=11'b10110000110 after idle -> sdata at the 11 sclk rising edges reads 1,0,1,1,0,0,0,0,1,1,0; shift-register model matches patron at slatch.
REQ-032 cargar pulses at busy cycles 5 and 30 -> ignored; exactly one listo; no restart if patron unchanged.
REQ-033 patron changes from 11'b11111111111 to 11'b10110000110 at busy cycle 10 -> first frame all ones, second frame starts the cycle after listo with new word.
REQ-034 rst_n low at busy cycle 20 -> outputs zero in same cycle, no slatch; after release full 11-bit frame resent.
REQ-035 CLK_DIV=1 -> busy length 24 cycles, sclk period 2 cycles, data stable at every sclk rising edge.
